machine_address_stepper: RTL and testbench

Registered, parametrised replacement for the combinational previous-address ±1 selector in the Machine front panel path. Holds the current memory address and steps it up or down from the panel buttons. Adds press-edge detection, hold-to-auto-repeat, configurable bounds, wrap or saturate mode, and a direct load port. It sits between the debounced button bank and the memory address mux, and drives the address display.

---
 rtl/machine_address_stepper_pkg.sv | 28 ++
 rtl/machine_addr_bound_step.sv | 64 ++++++
 rtl/machine_address_stepper.sv | 156 +++++++++++++++
 tb/tb_machine_address_stepper.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/machine_address_stepper_pkg.sv
// Shared types for the front-panel address stepper: button direction,
// stepper FSM states and the button-pair decode.
package Machine_types;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2
    } step_dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } stepper_state_t;

    // btn_hi is {decrement, increment}; both pressed means hold still.
    function automatic step_dir_t decode_dir(input logic [1:0] btn_hi);
        step_dir_t result;
        case (btn_hi)
            2'b01:   result = INC;
            2'b10:   result = DEC;
            default: result = NONE;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/machine_addr_bound_step.sv
// Combinational one-step address arithmetic with bound handling.
// Works one bit wider than the address so no modular overflow can occur;
// only the MIN/MAX bounds decide whether a step wraps or saturates.
module machine_addr_bound_step
    import Machine_types::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned ADDR_MIN = 0,
    parameter int unsigned ADDR_MAX = (1 << ADDR_W) - 1,
    parameter bit          WRAP     = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    input  step_dir_t         dir,
    output logic [ADDR_W-1:0] next_addr,
    output logic              changed,
    output logic              wrapped
);

    localparam logic [ADDR_W:0] MIN_X = (ADDR_W+1)'(ADDR_MIN);
    localparam logic [ADDR_W:0] MAX_X = (ADDR_W+1)'(ADDR_MAX);
    localparam logic [ADDR_W:0] ONE_X = (ADDR_W+1)'(1);

    logic [ADDR_W:0] addr_x;
    logic [ADDR_W:0] next_x;
    logic            bound_hit;

    // Compute the stepped address and whether it crossed a bound.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and a latch is never inferred.
        addr_x    = {1'b0, addr};
        next_x    = addr_x;
        bound_hit = 1'b0;
        case (dir)
            INC: begin
                if (addr_x >= MAX_X) begin
                    if (WRAP) begin
                        next_x    = MIN_X;
                        bound_hit = 1'b1;
                    end
                end else begin
                    next_x = addr_x + ONE_X;
                end
            end
            DEC: begin
                if (addr_x <= MIN_X) begin
                    if (WRAP) begin
                        next_x    = MAX_X;
                        bound_hit = 1'b1;
                    end
                end else begin
                    next_x = addr_x - ONE_X;
                end
            end
            default: begin
                next_x = addr_x;
            end
        endcase
        next_addr = next_x[ADDR_W-1:0];
        changed   = (next_x != addr_x);
        wrapped   = bound_hit & changed;
    end

endmodule

// File: rtl/machine_address_stepper.sv
// Registered front-panel address stepper: press-edge stepping,
// hold-to-auto-repeat, wrap/saturate bounds and a clamped direct load.
module machine_address_stepper
    import Machine_types::*;
#(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned ADDR_MIN      = 0,
    parameter int unsigned ADDR_MAX      = (1 << ADDR_W) - 1,
    parameter int unsigned ADDR_RESET    = ADDR_MIN,
    parameter bit          WRAP          = 1'b1,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned REPEAT_CYCLES = 4
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic [3:0]        btn,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              step,
    output logic              wrapped
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [ADDR_W:0]   MIN_X       = (ADDR_W+1)'(ADDR_MIN);
    localparam logic [ADDR_W:0]   MAX_X       = (ADDR_W+1)'(ADDR_MAX);
    localparam logic [ADDR_W-1:0] MIN_A       = ADDR_W'(ADDR_MIN);
    localparam logic [ADDR_W-1:0] MAX_A       = ADDR_W'(ADDR_MAX);
    localparam logic [ADDR_W-1:0] RESET_A     = ADDR_W'(ADDR_RESET);

    stepper_state_t    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    step_dir_t         dir_q, dir;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              step_q, step_d;
    logic              wrapped_q, wrapped_d;

    logic              do_step;
    logic [ADDR_W-1:0] bound_next;
    logic              bound_changed;
    logic              bound_wrapped;
    logic [ADDR_W:0]   load_x;

    // Buttons 1:0 belong to other panel functions.
    logic unused_btn_lo;
    assign unused_btn_lo = ^btn[1:0];

    assign dir    = decode_dir(btn[3:2]);
    assign load_x = {1'b0, load_addr};

    machine_addr_bound_step #(
        .ADDR_W   (ADDR_W),
        .ADDR_MIN (ADDR_MIN),
        .ADDR_MAX (ADDR_MAX),
        .WRAP     (WRAP)
    ) u_bound_step (
        .addr      (addr_q),
        .dir       (dir),
        .next_addr (bound_next),
        .changed   (bound_changed),
        .wrapped   (bound_wrapped)
    );

    // Next-state logic: load beats buttons, a direction change re-arms the
    // hold timer, and an unchanged held direction walks HOLD then REPEAT.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        step_d    = 1'b0;
        wrapped_d = 1'b0;
        do_step   = 1'b0;

        if (load_en) begin
            if (load_x > MAX_X) begin
                addr_d = MAX_A;
            end else if (load_x <= MIN_X) begin
                addr_d = MIN_A;
            end else begin
                addr_d = load_addr;
            end
            cnt_d   = '0;
            state_d = (dir != NONE) ? HOLD : IDLE;
        end else if (dir != dir_q) begin
            cnt_d = '0;
            if (dir != NONE) begin
                do_step = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = IDLE;
            end
        end else if (dir != NONE) begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        do_step = 1'b1;
                        state_d = REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (cnt_q == REPEAT_LAST) begin
                        do_step = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    // A held button seen in IDLE restarts the hold interval.
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        if (do_step) begin
            addr_d    = bound_next;
            step_d    = bound_changed;
            wrapped_d = bound_wrapped;
        end
    end

    // State, counter, previous direction and registered outputs.
    always_ff @(posedge system1000) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (!system1000_rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dir_q     <= NONE;
            addr_q    <= RESET_A;
            step_q    <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir;
            addr_q    <= addr_d;
            step_q    <= step_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign addr    = addr_q;
    assign step    = step_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_machine_address_stepper.sv
// Directed bench for machine_address_stepper. Four instances cover the
// default configuration, wrap and saturate at a small bound, and the load
// clamp. Inputs change 1 time unit after a rising edge; outputs are read at
// the same point, so each read reflects the edge that sampled the inputs.
module tb_machine_address_stepper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Default instance: 0..255, wrap, HOLD 16, REPEAT 4.
    logic       a_rstn = 1'b1, a_load_en = 1'b0, a_step, a_wrapped;
    logic [3:0] a_btn = 4'b0000;
    logic [7:0] a_load_addr = 8'd0, a_addr;
    // 0..9 with wrap.
    logic       b_rstn = 1'b1, b_load_en = 1'b0, b_step, b_wrapped;
    logic [3:0] b_btn = 4'b0000;
    logic [7:0] b_load_addr = 8'd0, b_addr;
    // 0..9 saturating.
    logic       c_rstn = 1'b1, c_load_en = 1'b0, c_step, c_wrapped;
    logic [3:0] c_btn = 4'b0000;
    logic [7:0] c_load_addr = 8'd0, c_addr;
    // 0..150 saturating.
    logic       d_rstn = 1'b1, d_load_en = 1'b0, d_step, d_wrapped;
    logic [3:0] d_btn = 4'b0000;
    logic [7:0] d_load_addr = 8'd0, d_addr;

    machine_address_stepper dut_a (
        .system1000(clk), .system1000_rstn(a_rstn), .btn(a_btn), .load_en(a_load_en),
        .load_addr(a_load_addr), .addr(a_addr), .step(a_step), .wrapped(a_wrapped)
    );
    machine_address_stepper #(.ADDR_MAX(9), .WRAP(1'b1)) dut_b (
        .system1000(clk), .system1000_rstn(b_rstn), .btn(b_btn), .load_en(b_load_en),
        .load_addr(b_load_addr), .addr(b_addr), .step(b_step), .wrapped(b_wrapped)
    );
    machine_address_stepper #(.ADDR_MAX(9), .WRAP(1'b0)) dut_c (
        .system1000(clk), .system1000_rstn(c_rstn), .btn(c_btn), .load_en(c_load_en),
        .load_addr(c_load_addr), .addr(c_addr), .step(c_step), .wrapped(c_wrapped)
    );
    machine_address_stepper #(.ADDR_MAX(150), .WRAP(1'b0)) dut_d (
        .system1000(clk), .system1000_rstn(d_rstn), .btn(d_btn), .load_en(d_load_en),
        .load_addr(d_load_addr), .addr(d_addr), .step(d_step), .wrapped(d_wrapped)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rstn = 1'b0; b_rstn = 1'b0; c_rstn = 1'b0; d_rstn = 1'b0;
        tick();
        a_rstn = 1'b1; b_rstn = 1'b1; c_rstn = 1'b1; d_rstn = 1'b1;
        n_vec++;
        if (a_addr !== 8'd0 || a_step !== 1'b0 || a_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL reset_a: addr=%0d step=%b wrapped=%b, expected 0 0 0", a_addr, a_step, a_wrapped);
        end
        n_vec++;
        if (b_addr !== 8'd0 || b_step !== 1'b0 || b_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL reset_b: addr=%0d step=%b wrapped=%b, expected 0 0 0", b_addr, b_step, b_wrapped);
        end
        n_vec++;
        if (c_addr !== 8'd0 || c_step !== 1'b0 || c_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL reset_c: addr=%0d step=%b wrapped=%b, expected 0 0 0", c_addr, c_step, c_wrapped);
        end
        n_vec++;
        if (d_addr !== 8'd0 || d_step !== 1'b0 || d_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL reset_d: addr=%0d step=%b wrapped=%b, expected 0 0 0", d_addr, d_step, d_wrapped);
        end
    endtask

    // One-cycle INC press: exactly one step, nothing afterwards.
    task automatic test_single_inc();
        a_btn = 4'b0100;
        tick();
        n_vec++;
        if (a_addr !== 8'd1 || a_step !== 1'b1 || a_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL single_inc_press: addr=%0d step=%b wrapped=%b, expected 1 1 0", a_addr, a_step, a_wrapped);
        end
        a_btn = 4'b0000;
        for (int k = 0; k < 24; k++) begin
            tick();
            n_vec++;
            if (a_addr !== 8'd1 || a_step !== 1'b0) begin
                n_err++;
                $display("FAIL single_inc_quiet k=%0d: addr=%0d step=%b, expected 1 0", k, a_addr, a_step);
            end
        end
    endtask

    // DEC held 30 cycles from 5: steps at 0, 16, 20, 24, 28 -> 5 steps, ends at 0.
    task automatic test_hold_dec();
        int         steps;
        logic       exp_step;
        logic [7:0] exp_addr;
        a_load_en = 1'b1; a_load_addr = 8'd5;
        tick();
        a_load_en = 1'b0;
        n_vec++;
        if (a_addr !== 8'd5 || a_step !== 1'b0) begin
            n_err++;
            $display("FAIL hold_dec_load: addr=%0d step=%b, expected 5 0", a_addr, a_step);
        end
        a_btn = 4'b1000;
        steps = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            exp_step = (c == 0) || (c == 16) || (c == 20) || (c == 24) || (c == 28);
            if (exp_step) steps++;
            exp_addr = 8'(5 - steps);
            n_vec++;
            if (a_addr !== exp_addr || a_step !== exp_step || a_wrapped !== 1'b0) begin
                n_err++;
                $display("FAIL hold_dec c=%0d: addr=%0d step=%b wrapped=%b, expected %0d %b 0",
                         c, a_addr, a_step, a_wrapped, exp_addr, exp_step);
            end
        end
        a_btn = 4'b0000;
        tick();
        n_vec++;
        if (a_addr !== 8'd0 || a_step !== 1'b0) begin
            n_err++;
            $display("FAIL hold_dec_release: addr=%0d step=%b, expected 0 0", a_addr, a_step);
        end
    endtask

    // Both buttons = hold still; releasing DEC leaves INC, an immediate step.
    task automatic test_both_pressed();
        a_btn = 4'b1100;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_vec++;
            if (a_addr !== 8'd0 || a_step !== 1'b0) begin
                n_err++;
                $display("FAIL both_pressed k=%0d: addr=%0d step=%b, expected 0 0", k, a_addr, a_step);
            end
        end
        a_btn = 4'b0100;
        tick();
        n_vec++;
        if (a_addr !== 8'd1 || a_step !== 1'b1 || a_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL both_release_dec: addr=%0d step=%b wrapped=%b, expected 1 1 0", a_addr, a_step, a_wrapped);
        end
        a_btn = 4'b0000;
        tick();
    endtask

    // Direct INC<->DEC reversals step every cycle; full-range wrap at 0/255.
    task automatic test_back_to_back();
        logic [3:0] seq_btn  [4] = '{4'b0100, 4'b1000, 4'b0100, 4'b0000};
        logic [7:0] seq_addr [4] = '{8'd2, 8'd1, 8'd2, 8'd2};
        logic       seq_step [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            a_btn = seq_btn[i];
            tick();
            n_vec++;
            if (a_addr !== seq_addr[i] || a_step !== seq_step[i]) begin
                n_err++;
                $display("FAIL back_to_back i=%0d: addr=%0d step=%b, expected %0d %b",
                         i, a_addr, a_step, seq_addr[i], seq_step[i]);
            end
        end
        a_load_en = 1'b1; a_load_addr = 8'd0;
        tick();
        a_load_en = 1'b0;
        a_btn = 4'b1000;
        tick();
        n_vec++;
        if (a_addr !== 8'd255 || a_step !== 1'b1 || a_wrapped !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_dec_full: addr=%0d step=%b wrapped=%b, expected 255 1 1", a_addr, a_step, a_wrapped);
        end
        a_btn = 4'b0100;
        tick();
        n_vec++;
        if (a_addr !== 8'd0 || a_step !== 1'b1 || a_wrapped !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_inc_full: addr=%0d step=%b wrapped=%b, expected 0 1 1", a_addr, a_step, a_wrapped);
        end
        a_btn = 4'b0000;
        tick();
        n_vec++;
        if (a_wrapped !== 1'b0 || a_step !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_pulse_end: step=%b wrapped=%b, expected 0 0", a_step, a_wrapped);
        end
    endtask

    // Small bound 9: wrap on dut_b, saturate on dut_c.
    task automatic test_wrap_bounds();
        b_load_en = 1'b1; b_load_addr = 8'd9;
        c_load_en = 1'b1; c_load_addr = 8'd9;
        tick();
        b_load_en = 1'b0; c_load_en = 1'b0;
        b_btn = 4'b0100; c_btn = 4'b0100;
        tick();
        n_vec++;
        if (b_addr !== 8'd0 || b_step !== 1'b1 || b_wrapped !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_inc_max9: addr=%0d step=%b wrapped=%b, expected 0 1 1", b_addr, b_step, b_wrapped);
        end
        n_vec++;
        if (c_addr !== 8'd9 || c_step !== 1'b0 || c_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL sat_inc_max9: addr=%0d step=%b wrapped=%b, expected 9 0 0", c_addr, c_step, c_wrapped);
        end
        b_btn = 4'b1000; c_btn = 4'b1000;
        tick();
        n_vec++;
        if (b_addr !== 8'd9 || b_step !== 1'b1 || b_wrapped !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_dec_min: addr=%0d step=%b wrapped=%b, expected 9 1 1", b_addr, b_step, b_wrapped);
        end
        n_vec++;
        if (c_addr !== 8'd8 || c_step !== 1'b1 || c_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL sat_dec_inside: addr=%0d step=%b wrapped=%b, expected 8 1 0", c_addr, c_step, c_wrapped);
        end
        b_btn = 4'b0000; c_btn = 4'b0000;
        c_load_en = 1'b1; c_load_addr = 8'd0;
        tick();
        c_load_en = 1'b0;
        c_btn = 4'b1000;
        tick();
        n_vec++;
        if (c_addr !== 8'd0 || c_step !== 1'b0 || c_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL sat_dec_min: addr=%0d step=%b wrapped=%b, expected 0 0 0", c_addr, c_step, c_wrapped);
        end
        c_btn = 4'b0000;
        tick();
    endtask

    // Load during REPEAT: clamp to 150, no step, then a fresh HOLD interval.
    task automatic test_load_in_repeat();
        int         steps;
        logic       exp_step;
        logic [7:0] exp_addr;
        d_load_en = 1'b1; d_load_addr = 8'd140;
        tick();
        d_load_en = 1'b0;
        d_btn = 4'b0100;
        steps = 0;
        for (int c = 0; c < 22; c++) begin
            tick();
            exp_step = (c == 0) || (c == 16) || (c == 20);
            if (exp_step) steps++;
            exp_addr = 8'(140 + steps);
            n_vec++;
            if (d_addr !== exp_addr || d_step !== exp_step) begin
                n_err++;
                $display("FAIL load_pre_repeat c=%0d: addr=%0d step=%b, expected %0d %b", c, d_addr, d_step, exp_addr, exp_step);
            end
        end
        d_load_en = 1'b1; d_load_addr = 8'd200;
        tick();
        d_load_en = 1'b0;
        n_vec++;
        if (d_addr !== 8'd150 || d_step !== 1'b0 || d_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL load_clamp: addr=%0d step=%b wrapped=%b, expected 150 0 0", d_addr, d_step, d_wrapped);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_vec++;
            if (d_addr !== 8'd150 || d_step !== 1'b0) begin
                n_err++;
                $display("FAIL load_saturate k=%0d: addr=%0d step=%b, expected 150 0", k, d_addr, d_step);
            end
        end
        // Same scenario below the bound makes the re-armed hold delay visible.
        d_load_en = 1'b1; d_load_addr = 8'd140;
        tick();
        d_load_en = 1'b0;
        n_vec++;
        if (d_addr !== 8'd140 || d_step !== 1'b0) begin
            n_err++;
            $display("FAIL load_held: addr=%0d step=%b, expected 140 0", d_addr, d_step);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_step = (k == 16);
            exp_addr = (k >= 16) ? 8'd141 : 8'd140;
            n_vec++;
            if (d_addr !== exp_addr || d_step !== exp_step) begin
                n_err++;
                $display("FAIL load_hold_delay k=%0d: addr=%0d step=%b, expected %0d %b", k, d_addr, d_step, exp_addr, exp_step);
            end
        end
        d_btn = 4'b0000;
        tick();
    endtask

    // Reset during REPEAT with INC held: back to 0, fresh press, full HOLD.
    task automatic test_reset_mid_repeat();
        int         steps;
        logic       exp_step;
        logic [7:0] exp_addr;
        a_load_en = 1'b1; a_load_addr = 8'd50;
        tick();
        a_load_en = 1'b0;
        a_btn = 4'b0100;
        steps = 0;
        for (int c = 0; c < 23; c++) begin
            tick();
            exp_step = (c == 0) || (c == 16) || (c == 20);
            if (exp_step) steps++;
            exp_addr = 8'(50 + steps);
            n_vec++;
            if (a_addr !== exp_addr || a_step !== exp_step) begin
                n_err++;
                $display("FAIL rst_pre_repeat c=%0d: addr=%0d step=%b, expected %0d %b", c, a_addr, a_step, exp_addr, exp_step);
            end
        end
        a_rstn = 1'b0;
        tick();
        a_rstn = 1'b1;
        n_vec++;
        if (a_addr !== 8'd0 || a_step !== 1'b0 || a_wrapped !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_repeat: addr=%0d step=%b wrapped=%b, expected 0 0 0", a_addr, a_step, a_wrapped);
        end
        tick();
        n_vec++;
        if (a_addr !== 8'd1 || a_step !== 1'b1) begin
            n_err++;
            $display("FAIL rst_fresh_press: addr=%0d step=%b, expected 1 1", a_addr, a_step);
        end
        for (int k = 1; k <= 18; k++) begin
            tick();
            exp_step = (k == 16);
            exp_addr = (k >= 16) ? 8'd2 : 8'd1;
            n_vec++;
            if (a_addr !== exp_addr || a_step !== exp_step) begin
                n_err++;
                $display("FAIL rst_hold_delay k=%0d: addr=%0d step=%b, expected %0d %b", k, a_addr, a_step, exp_addr, exp_step);
            end
        end
        a_btn = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_hold_dec();
        test_both_pressed();
        test_back_to_back();
        test_wrap_bounds();
        test_load_in_repeat();
        test_reset_mid_repeat();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
